// File: rtl/pixel_readout_pkg.sv
// pixel_readout_pkg: shared types and default timing constants for the pixel readout sequencer
package pixel_readout_pkg;
    localparam int NPIX      = 12;
    localparam int IW_DEF    = 16;
    localparam int T_SET_DEF = 4;
    localparam int T_RST_DEF = 16;
    localparam int T_SH_DEF  = 8;
    localparam int T_CMP_DEF = 4;
    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_RST, S_INT, S_SHP, S_CMP, S_NXT, S_DONE
    } state_t;
    typedef logic [3:0] pix_t;
endpackage

// File: rtl/pixel_readout_seq_phase_timer.sv
// phase_timer: loadable down-counter with terminal-count flag, shared by all timed phases
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val this cycle (phase entry)
//   load_val  : phase length minus one
//   tc        : counter has reached zero (last cycle of the phase)
module phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

    assign tc = cnt_q == '0;
endmodule

// File: rtl/pixel_readout_seq.sv
// pixel_readout_seq: sequences select/reset/integrate/sample/compare for each photodiode and collects comparator decisions
//   clk, rst    : clock, asynchronous active-high reset
//   start       : begin a frame (ignored while busy)
//   abort       : end the frame at the next edge, no done pulse
//   cont        : continuous mode, restart at pixel 0 after the last pixel
//   int_cycles  : integration length, latched at frame start (0 behaves as 1)
//   cmp_in      : asynchronous comparator output
//   busy, done  : frame in progress / one-cycle end-of-frame pulse
//   pix_idx     : pixel being sequenced
//   pd_a, pd_b  : one-hot pixel select / pixel reset switches
//   sw1, sw2    : integrator reset / integrator-to-S/H switches
//   sh_rst, sh, sh_cmp : reset-level, signal and comparator strobes
//   result      : comparator decision per pixel
module pixel_readout_seq
    import pixel_readout_pkg::*;
#(
    parameter int IW    = IW_DEF,
    parameter int T_SET = T_SET_DEF,
    parameter int T_RST = T_RST_DEF,
    parameter int T_SH  = T_SH_DEF,
    parameter int T_CMP = T_CMP_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            cont,
    input  logic [IW-1:0]   int_cycles,
    input  logic            cmp_in,
    output logic            busy,
    output logic            done,
    output logic [3:0]      pix_idx,
    output logic [NPIX-1:0] pd_a,
    output logic [NPIX-1:0] pd_b,
    output logic            sw1,
    output logic            sw2,
    output logic            sh_rst,
    output logic            sh,
    output logic            sh_cmp,
    output logic [NPIX-1:0] result
);
    state_t          state_q, state_d;
    pix_t            pix_q, pix_d;
    logic [IW-1:0]   n_q, n_d, n_new;
    logic [NPIX-1:0] result_q, result_d;
    logic            cmp_s1_q, cmp_s2_q;
    logic            load, tc, act;
    logic [IW-1:0]   load_val;
    logic            busy_q, busy_d, done_q, done_d;
    logic [NPIX-1:0] pd_a_q, pd_a_d, pd_b_q, pd_b_d;
    logic            sw1_q, sw1_d, sw2_q, sw2_d, sh_rst_q, sh_rst_d, sh_q, sh_d, sh_cmp_q, sh_cmp_d;

    phase_timer #(.W(IW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .tc       (tc)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cmp_s1_q <= 1'b0;
            cmp_s2_q <= 1'b0;
        end else begin
            cmp_s1_q <= cmp_in;
            cmp_s2_q <= cmp_s1_q;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q  <= S_IDLE;
            pix_q    <= '0;
            n_q      <= IW'(1);
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            pix_q    <= pix_d;
            n_q      <= n_d;
            result_q <= result_d;
        end

    assign n_new = int_cycles == '0 ? IW'(1) : int_cycles;

    always_comb begin
        state_d  = state_q;
        pix_d    = pix_q;
        n_d      = n_q;
        result_d = result_q;
        // abort also wins over start while idle
        if (abort) begin
            state_d = S_IDLE;
            pix_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    state_d  = S_SEL;
                    n_d      = n_new;
                    result_d = '0;
                    pix_d    = '0;
                end
                S_SEL: if (tc) state_d = S_RST;
                S_RST: if (tc) state_d = S_INT;
                S_INT: if (tc) state_d = S_SHP;
                S_SHP: if (tc) state_d = S_CMP;
                S_CMP: if (tc) begin
                    result_d[pix_q] = cmp_s2_q;
                    state_d         = S_NXT;
                end
                S_NXT: if (pix_q == pix_t'(NPIX - 1)) state_d = S_DONE;
                       else begin
                           pix_d   = pix_q + 1'b1;
                           state_d = S_SEL;
                       end
                S_DONE: begin
                    pix_d = '0;
                    if (cont) begin
                        state_d  = S_SEL;
                        n_d      = n_new;
                        result_d = '0;
                    end else state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // every timed phase is entered from a different state, so a state change marks phase entry
    always_comb begin
        load     = state_d != state_q;
        load_val = state_d == S_SEL ? IW'(T_SET - 1) :
                   state_d == S_RST ? IW'(T_RST - 1) :
                   state_d == S_INT ? n_d - 1'b1 :
                   state_d == S_SHP ? IW'(T_SH - 1) :
                   state_d == S_CMP ? IW'(T_CMP - 1) : '0;
    end

    // outputs are decoded from the next state and registered so they line up with the state
    always_comb begin
        act      = state_d inside {S_SEL, S_RST, S_INT, S_SHP, S_CMP};
        busy_d   = state_d != S_IDLE;
        done_d   = state_d == S_DONE;
        pd_a_d   = act ? NPIX'(1) << pix_d : '0;
        pd_b_d   = state_d == S_RST ? NPIX'(1) << pix_d : '0;
        sw1_d    = state_d == S_RST;
        sh_rst_d = state_d == S_RST;
        sw2_d    = state_d == S_SHP;
        sh_d     = state_d == S_SHP;
        sh_cmp_d = state_d == S_CMP;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pd_a_q   <= '0;
            pd_b_q   <= '0;
            sw1_q    <= 1'b0;
            sw2_q    <= 1'b0;
            sh_rst_q <= 1'b0;
            sh_q     <= 1'b0;
            sh_cmp_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            pd_a_q   <= pd_a_d;
            pd_b_q   <= pd_b_d;
            sw1_q    <= sw1_d;
            sw2_q    <= sw2_d;
            sh_rst_q <= sh_rst_d;
            sh_q     <= sh_d;
            sh_cmp_q <= sh_cmp_d;
        end

    assign busy    = busy_q;
    assign done    = done_q;
    assign pix_idx = pix_q;
    assign pd_a    = pd_a_q;
    assign pd_b    = pd_b_q;
    assign sw1     = sw1_q;
    assign sw2     = sw2_q;
    assign sh_rst  = sh_rst_q;
    assign sh      = sh_q;
    assign sh_cmp  = sh_cmp_q;
    assign result  = result_q;
endmodule

// File: tb/tb_pixel_readout_seq.sv
// tb_pixel_readout_seq: table-driven frame checks plus abort, continuous, mid-frame start and async reset sequences
module tb_pixel_readout_seq;
    logic        clk = 0, rst = 1, start = 0, abort = 0, cont = 0, cmp_in = 0;
    logic [15:0] int_cycles = 0;
    logic        busy, done, sw1, sw2, sh_rst, sh, sh_cmp;
    logic [3:0]  pix_idx;
    logic [11:0] pd_a, pd_b, result, pat;
    int checks = 0, failures = 0, viol = 0, pda_cnt = 0, done_cnt = 0;

    typedef struct {
        logic [15:0] ic;
        logic [11:0] pat;
        int          p;
        logic [11:0] res;
    } vec_t;
    vec_t vecs[5];

    pixel_readout_seq dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cont(cont),
        .int_cycles(int_cycles), .cmp_in(cmp_in), .busy(busy), .done(done),
        .pix_idx(pix_idx), .pd_a(pd_a), .pd_b(pd_b), .sw1(sw1), .sw2(sw2),
        .sh_rst(sh_rst), .sh(sh), .sh_cmp(sh_cmp), .result(result)
    );

    always #5 clk = ~clk;

    // comparator follows the pattern bit of the pixel being sequenced
    always @(negedge clk) cmp_in = pat[pix_idx];

    always @(negedge clk) begin
        if (sw1 && sw2) viol++;
        if (!$onehot0(pd_a) || !$onehot0(pd_b)) viol++;
        if (pd_a != 0 && pd_a != (12'd1 << pix_idx)) viol++;
        if (pd_a != 0) pda_cnt++;
        if (done) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic start_frame(input logic [15:0] ic);
        @(negedge clk);
        int_cycles = ic;
        start = 1;
        pda_cnt = 0;
        @(posedge clk);
        #1 start = 0;
    endtask

    // returns number of edges after the start edge until done is seen
    task automatic wait_done(input bit mid, output int t);
        t = 0;
        while (!done && t < 20000) begin
            start = mid && t == 50;
            if (mid && t == 50) int_cycles = 16'd100;
            @(posedge clk);
            #1 t++;
        end
        start = 0;
        if (!done) begin
            failures++;
            $display("FAIL done_timeout actual=0 required=1");
        end
    endtask

    task automatic run_vec(input vec_t v, input bit mid);
        int t;
        pat = v.pat;
        start_frame(v.ic);
        chk("busy_after_start", busy, 1);
        chk("pd_a_first", pd_a, 12'h001);
        chk("pix_first", pix_idx, 0);
        wait_done(mid, t);
        chk("done_cycle", t + 1, 12 * v.p + 1);
        chk("result", result, v.res);
        chk("pix_at_done", pix_idx, 11);
        chk("pda_cycles", pda_cnt, 12 * (v.p - 1));
        @(posedge clk);
        #1;
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        chk("result_hold", result, v.res);
    endtask

    initial begin
        int t, g;
        vecs[0] = '{16'd10, 12'hFFF, 43, 12'hFFF};
        vecs[1] = '{16'd10, 12'hA5C, 43, 12'hA5C};
        vecs[2] = '{16'd0,  12'h5A3, 34, 12'h5A3};
        vecs[3] = '{16'd1,  12'h123, 34, 12'h123};
        vecs[4] = '{16'd3,  12'h800, 36, 12'h800};
        pat = 12'hFFF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {busy, done, pix_idx, sw1, sw2, sh_rst, sh, sh_cmp}, 0);
        chk("reset_pd", {pd_a, pd_b}, 0);
        chk("reset_result", result, 0);
        @(negedge clk) rst = 0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], 0);

        // start mid-frame with a new int_cycles must not change the frame
        run_vec(vecs[2], 1);

        // abort during pixel 5 integration
        pat = 12'hFFF;
        start_frame(16'd10);
        t = 0;
        while (!(pix_idx == 5 && sw1) && t < 2000) begin @(posedge clk); #1 t++; end
        while (sw1 && t < 2000) begin @(posedge clk); #1 t++; end
        chk("abort_reached_int", {pix_idx, pd_a != 0, sw1, sw2, sh, sh_cmp}, {4'd5, 5'b10000});
        g = done_cnt;
        @(negedge clk) abort = 1;
        @(posedge clk);
        #1 abort = 0;
        chk("abort_ctrl", {busy, done, pix_idx, sw1, sw2, sh_rst, sh, sh_cmp}, 0);
        chk("abort_pd", {pd_a, pd_b}, 0);
        chk("abort_result", result, 12'h01F);
        repeat (600) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, g);
        chk("abort_idle", busy, 0);

        // abort beats start while idle
        @(negedge clk);
        abort = 1;
        start = 1;
        @(posedge clk);
        #1 abort = 0;
        start = 0;
        chk("abort_over_start", busy, 0);
        chk("abort_over_start_res", result, 12'h01F);

        // continuous mode: two back-to-back frames
        cont = 1;
        pat = 12'hC3A;
        start_frame(16'd10);
        wait_done(0, t);
        chk("cont_done1", t + 1, 517);
        chk("cont_res1", result, 12'hC3A);
        chk("cont_pix11", pix_idx, 11);
        @(posedge clk);
        #1;
        chk("cont_wrap", {busy, done, pix_idx}, {2'b10, 4'd0});
        chk("cont_clear", result, 0);
        @(negedge clk) cont = 0;
        g = 1;
        while (!done && g < 2000) begin @(posedge clk); #1 if (!done) g++; end
        chk("cont_gap", g, 516);
        chk("cont_res2", result, 12'hC3A);
        @(posedge clk);
        #1;
        chk("cont_stop", busy, 0);

        // asynchronous reset between edges
        start_frame(16'd10);
        repeat (30) @(posedge clk);
        #3 rst = 1;
        #1;
        chk("arst_ctrl", {busy, done, pix_idx, sw1, sw2, sh_rst, sh, sh_cmp}, 0);
        chk("arst_pd", {pd_a, pd_b}, 0);
        chk("arst_result", result, 0);
        @(negedge clk) rst = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("arst_stays_idle", busy, 0);

        chk("monitor_viol", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
